// File: rtl/iot_pkg.sv
// Shared definitions for the IoT event arbiter.
// Contents:
//   N_REQ_DEF       default number of device-event requesters
//   MAX_ACTIVE_DEF  default ceiling on the active-device count
//   CNT_W           width of the active-device count
//   state_e         arbiter FSM states
//   event_accepted  accept/reject rule for a single event
package iot_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int MAX_ACTIVE_DEF = 200;
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // An on-event needs headroom below the ceiling; an off-event needs a
  // non-zero count. Together these keep the counter from ever wrapping.
  function automatic logic event_accepted(input logic             on,
                                          input logic [CNT_W-1:0] count,
                                          input logic [CNT_W-1:0] max_active);
    logic ok;
    if (on) begin
      ok = (count < max_active);
    end else begin
      ok = (count != {CNT_W{1'b0}});
    end
    return ok;
  endfunction

endpackage

// File: rtl/iot_event_arbiter_if.sv
// Handshake bundle between the event requesters / active-device counter
// and the arbiter.
// Signals:
//   req, req_on_off  per-requester request and direction (to arbiter)
//   active_count     current active-device count (to arbiter)
//   grant, reject    one-hot one-cycle acknowledges (from arbiter)
//   change, on_off   counter increment/decrement strobe and direction
//   busy             arbiter is not idle
// Modports: slave = arbiter side, master = requester/counter side.
interface iot_event_arbiter_if #(
  parameter int N_REQ = iot_pkg::N_REQ_DEF
) ();
  import iot_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_on_off;
  logic [CNT_W-1:0] active_count;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] reject;
  logic             change;
  logic             on_off;
  logic             busy;

  modport slave (
    input  req, req_on_off, active_count,
    output grant, reject, change, on_off, busy
  );

  modport master (
    output req, req_on_off, active_count,
    input  grant, reject, change, on_off, busy
  );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin selector.
// Ports:
//   req_i     request vector
//   rr_ptr_i  index where the search starts
//   winner_o  index of the first set request at or after rr_ptr_i (wrapping)
//   valid_o   at least one request is set
module rr_select import iot_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  int               pos_s;
  logic [IDX_W-1:0] idx_s;

  // Scan from the pointer upward with wrap; the first hit wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    pos_s    = 0;
    idx_s    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos_s = int'(rr_ptr_i) + i;
      if (pos_s >= N_REQ) begin
        pos_s = pos_s - N_REQ;
      end else begin
        pos_s = pos_s;
      end
      idx_s = IDX_W'(pos_s);
      if (!valid_o && req_i[idx_s]) begin
        valid_o  = 1'b1;
        winner_o = idx_s;
      end else begin
        valid_o  = valid_o;
      end
    end
  end

endmodule

// File: rtl/iot_event_arbiter.sv
// Round-robin arbiter for device on/off events feeding an active-device
// counter. One event is decided per IDLE -> ISSUE -> SETTLE pass: the
// decision is taken in IDLE, the ack/strobe appears in ISSUE, and SETTLE
// gives the counter a cycle to update before the next decision.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  iot_event_arbiter_if slave modport (req, req_on_off, active_count
//        in; grant, reject, change, on_off, busy out, all registered)
module iot_event_arbiter import iot_pkg::*; #(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int MAX_ACTIVE = MAX_ACTIVE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  iot_event_arbiter_if.slave   bus
);

  localparam int               IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_ACTIVE);
  localparam logic [N_REQ-1:0] ONE_HOT_0 = N_REQ'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

  state_e           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] reject_q;
  logic             change_q;
  logic             on_off_q;
  logic             busy_q;

  logic [IDX_W-1:0] winner_s;
  logic             valid_s;
  logic             dir_s;
  logic             accept_d;
  logic [N_REQ-1:0] ack_vec_d;
  logic [IDX_W-1:0] rr_ptr_d;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .winner_o (winner_s),
    .valid_o  (valid_s)
  );

  // Decision for the current winner, plus the pointer value after it.
  always_comb begin
    dir_s     = bus.req_on_off[winner_s];
    accept_d  = event_accepted(dir_s, bus.active_count, MAX_CNT);
    ack_vec_d = ONE_HOT_0 << winner_s;
    if (winner_s == LAST_IDX) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = winner_s + 1'b1;
    end
  end

  // FSM, round-robin pointer and registered outputs. Strobes are loaded on
  // the IDLE->ISSUE edge so they are visible exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      reject_q <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      grant_q  <= '0;
      reject_q <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_s) begin
            state_q  <= ST_ISSUE;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
            if (accept_d) begin
              grant_q  <= ack_vec_d;
              change_q <= 1'b1;
              on_off_q <= dir_s;
            end else begin
              reject_q <= ack_vec_d;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_SETTLE;
          busy_q  <= 1'b1;
        end
        ST_SETTLE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.reject = reject_q;
  assign bus.change = change_q;
  assign bus.on_off = on_off_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Self-checking bench for iot_event_arbiter with a behavioural active-device
// counter in the loop. Expected acks are queued when a request is driven and
// popped whenever the DUT acknowledges.
module tb_iot_event_arbiter;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] reject;
    logic         change;
    logic         on_off;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cnt;
  logic       load_en;
  logic [7:0] load_val;

  int   n_checks  = 0;
  int   n_errors  = 0;
  int   cycle     = 0;
  int   model_cnt = 0;
  exp_t exp_q[$];
  int   ack_cyc[$];

  iot_event_arbiter_if #(.N_REQ(N)) bus ();

  iot_event_arbiter #(
    .N_REQ      (N),
    .MAX_ACTIVE (200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Active-device counter driven by the arbiter's change strobe.
  always @(posedge clk) begin
    if (load_en) begin
      cnt <= load_val;
    end else if (bus.change) begin
      cnt <= bus.on_off ? cnt + 8'd1 : cnt - 8'd1;
    end
  end

  assign bus.active_count = cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cycle);
    end
  endtask

  function automatic logic predict_accept(input logic on, input int c);
    if (on) return (c < 200);
    return (c != 0);
  endfunction

  task automatic expect_ev(input logic [N-1:0] vec, input logic on, input logic acc);
    exp_t e;
    e.grant  = acc ? vec : 4'd0;
    e.reject = acc ? 4'd0 : vec;
    e.change = acc;
    e.on_off = acc & on;
    exp_q.push_back(e);
    if (acc) model_cnt = on ? model_cnt + 1 : model_cnt - 1;
  endtask

  // One cycle: sample on the falling edge, score any ack, and let the
  // acknowledged requester drop its req.
  task automatic tick();
    logic [N-1:0] ack;
    exp_t         e;
    @(negedge clk);
    cycle++;
    ack = bus.grant | bus.reject;
    check_val("gnt_rej_overlap", 32'(bus.grant & bus.reject), 32'd0);
    if (ack != 4'd0) begin
      ack_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        check_val("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("grant", 32'(bus.grant), 32'(e.grant));
        check_val("reject", 32'(bus.reject), 32'(e.reject));
        check_val("change", 32'(bus.change), 32'(e.change));
        if (e.change) check_val("on_off", 32'(bus.on_off), 32'(e.on_off));
      end
      bus.req = bus.req & ~ack;
    end else begin
      check_val("change_without_ack", 32'(bus.change), 32'd0);
    end
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || bus.req != 4'd0) && k < lim) begin
      tick();
      k++;
    end
    check_val("timeout", 32'(exp_q.size() == 0 && bus.req == 4'd0), 32'd1);
    exp_q.delete();
    bus.req = 4'd0;
    tick();
    tick();
  endtask

  task automatic load(input logic [7:0] v);
    load_val  = v;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
    model_cnt = int'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int           a0;
    int           idx;
    logic         on;
    logic [N-1:0] vec;

    rst            = 1'b1;
    bus.req        = 4'd0;
    bus.req_on_off = 4'd0;
    load_en        = 1'b1;
    load_val       = 8'd0;
    tick();
    tick();
    check_val("rst_grant", 32'(bus.grant), 32'd0);
    check_val("rst_reject", 32'(bus.reject), 32'd0);
    check_val("rst_change", 32'(bus.change), 32'd0);
    check_val("rst_on_off", 32'(bus.on_off), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    rst     = 1'b0;
    load_en = 1'b0;

    // Single request, latency and busy window.
    load(8'd5);
    expect_ev(4'b0001, 1'b1, 1'b1);
    bus.req_on_off = 4'b0001;
    bus.req        = 4'b0001;
    a0 = ack_cyc.size();
    tick();
    check_val("t1_ack", 32'(ack_cyc.size() - a0), 32'd1);
    check_val("t1_busy", 32'(bus.busy), 32'd1);
    tick();
    check_val("t2_busy", 32'(bus.busy), 32'd1);
    check_val("t2_strobes", 32'({bus.grant, bus.reject, bus.change}), 32'd0);
    tick();
    check_val("t3_busy", 32'(bus.busy), 32'd0);
    check_val("cnt_after_on", 32'(cnt), 32'd6);

    // Round-robin over all four held requests, starting from pointer 0.
    do_reset();
    ack_cyc.delete();
    expect_ev(4'b0001, 1'b1, 1'b1);
    expect_ev(4'b0010, 1'b1, 1'b1);
    expect_ev(4'b0100, 1'b1, 1'b1);
    expect_ev(4'b1000, 1'b1, 1'b1);
    bus.req_on_off = 4'b1111;
    bus.req        = 4'b1111;
    wait_done(40);
    check_val("rr_ack_count", 32'(ack_cyc.size()), 32'd4);
    for (int i = 0; i < ack_cyc.size() - 1; i++) begin
      check_val("rr_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd3);
    end
    // Pointer back at 0: bit 0 must beat bit 3.
    expect_ev(4'b0001, 1'b1, 1'b1);
    expect_ev(4'b1000, 1'b1, 1'b1);
    bus.req_on_off = 4'b1001;
    bus.req        = 4'b1001;
    wait_done(20);
    check_val("cnt_rr", 32'(cnt), 32'(model_cnt));

    // Full counter: on rejected, off granted.
    load(8'd200);
    expect_ev(4'b0100, 1'b1, 1'b0);
    bus.req_on_off = 4'b0100;
    bus.req        = 4'b0100;
    wait_done(10);
    check_val("cnt_full_hold", 32'(cnt), 32'd200);
    expect_ev(4'b0100, 1'b0, 1'b1);
    bus.req_on_off = 4'b0000;
    bus.req        = 4'b0100;
    wait_done(10);
    check_val("cnt_full_off", 32'(cnt), 32'd199);

    // Empty counter: off rejected.
    load(8'd0);
    expect_ev(4'b0010, 1'b0, 1'b0);
    bus.req_on_off = 4'b0000;
    bus.req        = 4'b0010;
    wait_done(10);
    check_val("cnt_empty_hold", 32'(cnt), 32'd0);

    // Reset while in ISSUE.
    load(8'd5);
    expect_ev(4'b0001, 1'b1, 1'b1);
    bus.req_on_off = 4'b0001;
    bus.req        = 4'b0001;
    tick();
    rst = 1'b1;
    tick();
    check_val("mid_rst_outs", 32'({bus.grant, bus.reject, bus.change, bus.on_off}), 32'd0);
    check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    expect_ev(4'b0001, 1'b1, 1'b1);
    expect_ev(4'b1000, 1'b1, 1'b1);
    bus.req_on_off = 4'b1001;
    bus.req        = 4'b1001;
    wait_done(20);
    check_val("cnt_mid_rst", 32'(cnt), 32'(model_cnt));

    // Closed loop: 50 random single-requester events near the ceiling.
    do_reset();
    load(8'd195);
    for (int n = 0; n < 50; n++) begin
      idx = int'($urandom_range(0, 3));
      on  = ($urandom_range(0, 9) < 7);
      vec = 4'b0001 << idx;
      expect_ev(vec, on, predict_accept(on, model_cnt));
      bus.req_on_off = on ? vec : 4'b0000;
      bus.req        = vec;
      wait_done(20);
      check_val("cnt_model", 32'(cnt), 32'(model_cnt));
      check_val("cnt_range", 32'(cnt <= 8'd200), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
